param_reg_file: RTL and testbench
=================================

Name: param_reg_file

Overview:
- Parametrised successor to the 8-bit, 4+4 register file in the CPU datapath: NUM_R general registers and NUM_T temporary registers, each WIDTH bits wide.
- Per-register select vectors; 3-bit function code with shift and hold modes added.
- Optional saturating increment/decrement, optional write-to-read bypass, and a per-cycle wrap/saturate event flag.
- Feeds the ALU operand muxes through two registered read ports, O1 and O2.

Parameters:
- WIDTH, 8, register and data width in bits (>=2)
- NUM_R, 4, number of general registers R1..R{NUM_R} (>=1)
- NUM_T, 4, number of temporary registers T1..T{NUM_T} (>=1)
- SATURATE, 0, 1: inc/dec clamp at all-ones/zero; 0: modular wrap
- BYPASS, 0, 1: read ports return the post-update value of a register written in the same cycle
- SEL_W, clog2(NUM_R+NUM_T), read-select width (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- I  in  WIDTH  load data
- FunSel  in  3  function code (see Behaviour)
- RSel  in  NUM_R  write enables; bit NUM_R-1 = R1 ... bit 0 = R{NUM_R}
- TSel  in  NUM_T  write enables; bit NUM_T-1 = T1 ... bit 0 = T{NUM_T}
- O1Sel  in  SEL_W  read select for port 1
- O2Sel  in  SEL_W  read select for port 2
- O1  out  WIDTH  registered read port 1
- O2  out  WIDTH  registered read port 2
- wrap  out  1  registered; 1 for one cycle after any selected register wraps or saturates

Behaviour:
- Reset (async, rst=1): all R and T registers = 0, O1 = 0, O2 = 0, wrap = 0. Held while rst=1. First update occurs on the first rising edge after deassertion.
- FunSel codes, applied on the rising edge to every register whose select bit is 1. Unselected registers hold.
  - 000 clear to 0
  - 001 load I
  - 010 decrement by 1
  - 011 increment by 1
  - 100 logical shift left, LSB <= 0
  - 101 logical shift right, MSB <= 0
  - 110 hold
  - 111 set to all-ones
- Multiple select bits may be 1 at once. All selected registers update in parallel, each from its own old value.
- Read index map: 0..NUM_T-1 = T1..T{NUM_T}; NUM_T..NUM_T+NUM_R-1 = R1..R{NUM_R}. An index >= NUM_T+NUM_R reads 0.
- Read latency is one cycle: O1/O2 are sampled at the same edge as the write.
  - BYPASS=0: O returns the pre-edge value of the register (old value).
  - BYPASS=1: O returns the value being written at that edge (new value, or the held value if unselected).
  - O1Sel == O2Sel is legal; both ports return the same value.
- wrap is set at the edge when any selected register meets one of these conditions; otherwise it is 0 at that edge:
  - inc from all-ones, or dec from 0. With SATURATE=0 the value wraps to 0 / all-ones. With SATURATE=1 it stays at all-ones / 0.
  - Shift events never set wrap.
- SATURATE affects only codes 010 and 011.
- Reset asserted mid-operation overrides any in-flight update. No partial state survives.

Decomposition:
- Shared package reg_file_pkg:
  - FunSel localparams (FS_CLR, FS_LOAD, FS_DEC, FS_INC, FS_SHL, FS_SHR, FS_HOLD, FS_SET)
  - Read-index helper function mapping {T,R} position to index
- One sub-module, reg_cell:
  - A single WIDTH register holding the FunSel next-value logic and SATURATE handling.
  - Outputs: q, next value, and a wrap event.
  - Instantiated NUM_R+NUM_T times via generate.
- Read muxes and wrap OR-reduction live in param_reg_file.

Test Plan:
1. Defaults. Reset, then load I=8'hA5 into R1 (RSel=4'b1000, FunSel=001). Next cycle set O1Sel=3'd4 -> O1=8'hA5 after the edge; O2Sel=3'd0 -> O2=8'h00.
2. Wrap, SATURATE=0. Load T4=8'hFF, then inc with TSel=4'b0001 -> T4=8'h00 and wrap=1 for exactly one cycle. Then dec -> T4=8'hFF and wrap=1.
3. SATURATE=1. Load R2=8'hFE, then inc twice -> R2 reads 8'hFF then 8'hFF; wrap=0 after the first inc, wrap=1 after the second. Clear then dec -> R2=8'h00, wrap=1.
4. BYPASS comparison. Load R3=8'h10 with O1Sel=3'd6 in the same cycle. BYPASS=0 -> O1 shows the prior value (8'h00). BYPASS=1 -> O1=8'h10.
5. Multi-select shifts. Load all 8 registers with 8'h81, then FunSel=100 with RSel=4'b1111 and TSel=4'b0000 -> every R reads 8'h02, every T reads 8'h81. Then FunSel=101 on all R -> 8'h01.
6. Async reset mid-increment. Assert rst between edges during a run of incs -> O1/O2/wrap go to 0 immediately, without waiting for a clock edge. After release, all registers read 0. NUM_R=3, NUM_T=2 build: out-of-range index 3'd7 reads 0.

Source files
------------

// File: rtl/param_reg_file_pkg.sv
// Shared definitions for param_reg_file: function codes and the read-index map.
package reg_file_pkg;

    typedef enum logic [2:0] {
        FS_CLR  = 3'b000,
        FS_LOAD = 3'b001,
        FS_DEC  = 3'b010,
        FS_INC  = 3'b011,
        FS_SHL  = 3'b100,
        FS_SHR  = 3'b101,
        FS_HOLD = 3'b110,
        FS_SET  = 3'b111
    } funsel_e;

    // T registers occupy the low indices, R registers follow; pos is 0-based (T1/R1 = 0)
    function automatic int unsigned rd_index(input logic is_r, input int unsigned pos,
                                             input int unsigned num_t);
        return is_r ? num_t + pos : pos;
    endfunction

endpackage

// File: rtl/param_reg_file_if.sv
// Control/data bus between the datapath controller and param_reg_file.
interface param_reg_file_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NUM_R = 4,
    parameter int unsigned NUM_T = 4
);
    localparam int unsigned SEL_W = $clog2(NUM_R + NUM_T);

    logic [WIDTH-1:0] I;
    logic [2:0]       FunSel;
    logic [NUM_R-1:0] RSel;
    logic [NUM_T-1:0] TSel;
    logic [SEL_W-1:0] O1Sel;
    logic [SEL_W-1:0] O2Sel;
    logic [WIDTH-1:0] O1;
    logic [WIDTH-1:0] O2;
    logic             wrap;

    modport master (output I, FunSel, RSel, TSel, O1Sel, O2Sel,
                    input  O1, O2, wrap);
    modport slave  (input  I, FunSel, RSel, TSel, O1Sel, O2Sel,
                    output O1, O2, wrap);
endinterface

// File: rtl/param_reg_file_reg_cell.sv
// One register of the file: function-code next-value logic with optional saturation.
module reg_cell
    import reg_file_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  funsel_e          fun,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nxt,
    output logic             wrap_ev
);

    always_comb begin
        nxt     = q;
        wrap_ev = 1'b0;
        if (sel) begin
            case (fun)
                FS_CLR:  nxt = '0;
                FS_LOAD: nxt = d;
                FS_DEC: begin
                    if (q == '0) begin
                        wrap_ev = 1'b1;
                        nxt     = (SATURATE != 0) ? '0 : '1;
                    end else begin
                        nxt = q - 1'b1;
                    end
                end
                FS_INC: begin
                    if (q == '1) begin
                        wrap_ev = 1'b1;
                        nxt     = (SATURATE != 0) ? '1 : '0;
                    end else begin
                        nxt = q + 1'b1;
                    end
                end
                FS_SHL:  nxt = {q[WIDTH-2:0], 1'b0};
                FS_SHR:  nxt = {1'b0, q[WIDTH-1:1]};
                FS_SET:  nxt = '1;
                default: nxt = q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else     q <= nxt;
    end

endmodule

// File: rtl/param_reg_file.sv
// NUM_R general + NUM_T temporary registers with two registered read ports and a wrap flag.
module param_reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned NUM_R    = 4,
    parameter int unsigned NUM_T    = 4,
    parameter int unsigned SATURATE = 0,
    parameter int unsigned BYPASS   = 0
) (
    input logic            clk,
    input logic            rst,
    param_reg_file_if.slave bus
);

    localparam int unsigned NTOT = NUM_R + NUM_T;

    logic [WIDTH-1:0] q_a   [NTOT];
    logic [WIDTH-1:0] nxt_a [NTOT];
    logic [NTOT-1:0]  sel;
    logic [NTOT-1:0]  ev;
    logic [WIDTH-1:0] rd1, rd2;
    funsel_e          fun;

    assign fun = funsel_e'(bus.FunSel);

    // Select vectors are MSB-first (bit N-1 = register 1); remap into read-index order
    for (genvar j = 0; j < NUM_T; j++) begin : g_tsel
        assign sel[rd_index(1'b0, j, NUM_T)] = bus.TSel[NUM_T-1-j];
    end
    for (genvar j = 0; j < NUM_R; j++) begin : g_rsel
        assign sel[rd_index(1'b1, j, NUM_T)] = bus.RSel[NUM_R-1-j];
    end

    for (genvar k = 0; k < NTOT; k++) begin : g_cell
        reg_cell #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_cell (
            .clk     (clk),
            .rst     (rst),
            .sel     (sel[k]),
            .fun     (fun),
            .d       (bus.I),
            .q       (q_a[k]),
            .nxt     (nxt_a[k]),
            .wrap_ev (ev[k])
        );
    end

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        for (int unsigned k = 0; k < NTOT; k++) begin
            if (32'(bus.O1Sel) == k) rd1 = (BYPASS != 0) ? nxt_a[k] : q_a[k];
            if (32'(bus.O2Sel) == k) rd2 = (BYPASS != 0) ? nxt_a[k] : q_a[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.O1   <= '0;
            bus.O2   <= '0;
            bus.wrap <= 1'b0;
        end else begin
            bus.O1   <= rd1;
            bus.O2   <= rd2;
            bus.wrap <= |ev;
        end
    end

endmodule

// File: tb/tb_param_reg_file.sv
// Directed bench for param_reg_file across default, saturating, bypass and 3+2 builds.
module tb_param_reg_file;
    import reg_file_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    param_reg_file_if #(.WIDTH(8), .NUM_R(4), .NUM_T(4)) b0 ();
    param_reg_file_if #(.WIDTH(8), .NUM_R(4), .NUM_T(4)) bs ();
    param_reg_file_if #(.WIDTH(8), .NUM_R(4), .NUM_T(4)) bb ();
    param_reg_file_if #(.WIDTH(8), .NUM_R(3), .NUM_T(2)) bn ();

    param_reg_file #(.WIDTH(8), .NUM_R(4), .NUM_T(4), .SATURATE(0), .BYPASS(0))
        dut0 (.clk(clk), .rst(rst), .bus(b0));
    param_reg_file #(.WIDTH(8), .NUM_R(4), .NUM_T(4), .SATURATE(1), .BYPASS(0))
        dut_sat (.clk(clk), .rst(rst), .bus(bs));
    param_reg_file #(.WIDTH(8), .NUM_R(4), .NUM_T(4), .SATURATE(0), .BYPASS(1))
        dut_byp (.clk(clk), .rst(rst), .bus(bb));
    param_reg_file #(.WIDTH(8), .NUM_R(3), .NUM_T(2), .SATURATE(0), .BYPASS(0))
        dut_small (.clk(clk), .rst(rst), .bus(bn));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        b0.I = 8'h5A; b0.FunSel = FS_SET; b0.RSel = '1; b0.TSel = '1; b0.O1Sel = 3'd4; b0.O2Sel = 3'd0;
        bs.I = 8'h5A; bs.FunSel = FS_SET; bs.RSel = '1; bs.TSel = '1; bs.O1Sel = 3'd4; bs.O2Sel = 3'd0;
        bb.I = 8'h5A; bb.FunSel = FS_SET; bb.RSel = '1; bb.TSel = '1; bb.O1Sel = 3'd4; bb.O2Sel = 3'd0;
        bn.I = 8'h5A; bn.FunSel = FS_SET; bn.RSel = '1; bn.TSel = '1; bn.O1Sel = 3'd2; bn.O2Sel = 3'd0;
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({b0.O1, b0.O2, b0.wrap} !== 17'd0) begin
            failures++; $display("FAIL reset_dut0 got=%h/%h/%b exp=00/00/0", b0.O1, b0.O2, b0.wrap);
        end
        checks++;
        if ({bs.O1, bs.O2, bs.wrap} !== 17'd0) begin
            failures++; $display("FAIL reset_sat got=%h/%h/%b exp=00/00/0", bs.O1, bs.O2, bs.wrap);
        end
        checks++;
        if ({bb.O1, bb.O2, bb.wrap} !== 17'd0) begin
            failures++; $display("FAIL reset_byp got=%h/%h/%b exp=00/00/0", bb.O1, bb.O2, bb.wrap);
        end
        checks++;
        if ({bn.O1, bn.O2, bn.wrap} !== 17'd0) begin
            failures++; $display("FAIL reset_small got=%h/%h/%b exp=00/00/0", bn.O1, bn.O2, bn.wrap);
        end
        rst = 1'b0;
        b0.FunSel = FS_HOLD; b0.RSel = '0; b0.TSel = '0;
        bs.FunSel = FS_HOLD; bs.RSel = '0; bs.TSel = '0;
        bb.FunSel = FS_HOLD; bb.RSel = '0; bb.TSel = '0;
        bn.FunSel = FS_HOLD; bn.RSel = '0; bn.TSel = '0;
    endtask

    task automatic test_defaults();
        b0.I = 8'hA5; b0.FunSel = FS_LOAD; b0.RSel = 4'b1000;
        tick();
        b0.FunSel = FS_HOLD; b0.RSel = 4'b0000; b0.O1Sel = 3'd4; b0.O2Sel = 3'd0;
        tick();
        checks++;
        if (b0.O1 !== 8'hA5) begin failures++; $display("FAIL dflt_r1 got=%h exp=a5", b0.O1); end
        checks++;
        if (b0.O2 !== 8'h00) begin failures++; $display("FAIL dflt_t1 got=%h exp=00", b0.O2); end
    endtask

    task automatic test_wrap_modular();
        b0.I = 8'hFF; b0.FunSel = FS_LOAD; b0.TSel = 4'b0001; b0.O1Sel = 3'd3;
        tick();
        checks++;
        if (b0.wrap !== 1'b0) begin failures++; $display("FAIL wrap_load got=%b exp=0", b0.wrap); end
        b0.FunSel = FS_INC;
        tick();
        checks++;
        if (b0.wrap !== 1'b1) begin failures++; $display("FAIL wrap_inc got=%b exp=1", b0.wrap); end
        b0.FunSel = FS_HOLD; b0.TSel = 4'b0000;
        tick();
        checks++;
        if (b0.wrap !== 1'b0) begin failures++; $display("FAIL wrap_one_cycle got=%b exp=0", b0.wrap); end
        checks++;
        if (b0.O1 !== 8'h00) begin failures++; $display("FAIL wrap_inc_val got=%h exp=00", b0.O1); end
        b0.FunSel = FS_DEC; b0.TSel = 4'b0001;
        tick();
        checks++;
        if (b0.wrap !== 1'b1) begin failures++; $display("FAIL wrap_dec got=%b exp=1", b0.wrap); end
        b0.FunSel = FS_HOLD; b0.TSel = 4'b0000;
        tick();
        checks++;
        if (b0.O1 !== 8'hFF) begin failures++; $display("FAIL wrap_dec_val got=%h exp=ff", b0.O1); end
    endtask

    task automatic test_saturate();
        bs.I = 8'hFE; bs.FunSel = FS_LOAD; bs.RSel = 4'b0100; bs.O1Sel = 3'd5;
        tick();
        bs.FunSel = FS_INC;
        tick();
        checks++;
        if (bs.wrap !== 1'b0) begin failures++; $display("FAIL sat_inc1_wrap got=%b exp=0", bs.wrap); end
        tick();
        checks++;
        if (bs.wrap !== 1'b1) begin failures++; $display("FAIL sat_inc2_wrap got=%b exp=1", bs.wrap); end
        checks++;
        if (bs.O1 !== 8'hFF) begin failures++; $display("FAIL sat_inc1_val got=%h exp=ff", bs.O1); end
        bs.FunSel = FS_HOLD; bs.RSel = 4'b0000;
        tick();
        checks++;
        if (bs.O1 !== 8'hFF) begin failures++; $display("FAIL sat_inc2_val got=%h exp=ff", bs.O1); end
        bs.FunSel = FS_CLR; bs.RSel = 4'b0100;
        tick();
        bs.FunSel = FS_DEC;
        tick();
        checks++;
        if (bs.wrap !== 1'b1) begin failures++; $display("FAIL sat_dec_wrap got=%b exp=1", bs.wrap); end
        bs.FunSel = FS_HOLD; bs.RSel = 4'b0000;
        tick();
        checks++;
        if (bs.O1 !== 8'h00) begin failures++; $display("FAIL sat_dec_val got=%h exp=00", bs.O1); end
    endtask

    task automatic test_bypass();
        b0.I = 8'h10; b0.FunSel = FS_LOAD; b0.RSel = 4'b0010; b0.O1Sel = 3'd6;
        bb.I = 8'h10; bb.FunSel = FS_LOAD; bb.RSel = 4'b0010; bb.O1Sel = 3'd6; bb.O2Sel = 3'd6;
        tick();
        checks++;
        if (b0.O1 !== 8'h00) begin failures++; $display("FAIL byp0_old got=%h exp=00", b0.O1); end
        checks++;
        if (bb.O1 !== 8'h10) begin failures++; $display("FAIL byp1_new got=%h exp=10", bb.O1); end
        checks++;
        if (bb.O2 !== 8'h10) begin failures++; $display("FAIL byp1_same_sel got=%h exp=10", bb.O2); end
        b0.FunSel = FS_HOLD; b0.RSel = 4'b0000;
        bb.FunSel = FS_HOLD; bb.RSel = 4'b0000;
    endtask

    task automatic test_multi_shift();
        b0.I = 8'h81; b0.FunSel = FS_LOAD; b0.RSel = 4'b1111; b0.TSel = 4'b1111;
        tick();
        b0.FunSel = FS_SHL; b0.TSel = 4'b0000;
        tick();
        checks++;
        if (b0.wrap !== 1'b0) begin failures++; $display("FAIL shl_no_wrap got=%b exp=0", b0.wrap); end
        b0.FunSel = FS_SHR; b0.O1Sel = 3'd4; b0.O2Sel = 3'd0;
        tick();
        checks++;
        if (b0.O1 !== 8'h02) begin failures++; $display("FAIL shl_r1 got=%h exp=02", b0.O1); end
        checks++;
        if (b0.O2 !== 8'h81) begin failures++; $display("FAIL shl_t1 got=%h exp=81", b0.O2); end
        b0.FunSel = FS_HOLD; b0.RSel = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            b0.O1Sel = 3'(k);
            b0.O2Sel = 3'(k + 4);
            tick();
            checks++;
            if (b0.O1 !== 8'h81) begin failures++; $display("FAIL shr_t%0d got=%h exp=81", k + 1, b0.O1); end
            checks++;
            if (b0.O2 !== 8'h01) begin failures++; $display("FAIL shr_r%0d got=%h exp=01", k + 1, b0.O2); end
        end
    endtask

    task automatic test_out_of_range();
        bn.I = 8'hFF; bn.FunSel = FS_LOAD; bn.RSel = 3'b111; bn.TSel = 2'b11;
        tick();
        bn.FunSel = FS_HOLD; bn.RSel = 3'b000; bn.TSel = 2'b00; bn.O1Sel = 3'd7; bn.O2Sel = 3'd4;
        tick();
        checks++;
        if (bn.O1 !== 8'h00) begin failures++; $display("FAIL oor_idx7 got=%h exp=00", bn.O1); end
        checks++;
        if (bn.O2 !== 8'hFF) begin failures++; $display("FAIL small_r3 got=%h exp=ff", bn.O2); end
        bn.O1Sel = 3'd5;
        tick();
        checks++;
        if (bn.O1 !== 8'h00) begin failures++; $display("FAIL oor_idx5 got=%h exp=00", bn.O1); end
    endtask

    task automatic test_async_reset();
        b0.I = 8'hFE; b0.FunSel = FS_LOAD; b0.RSel = 4'b1000; b0.O1Sel = 3'd4; b0.O2Sel = 3'd4;
        tick();
        b0.FunSel = FS_INC;
        tick();
        tick();
        checks++;
        if (b0.wrap !== 1'b1 || b0.O1 !== 8'hFF) begin
            failures++; $display("FAIL pre_rst got=%h/%b exp=ff/1", b0.O1, b0.wrap);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({b0.O1, b0.O2, b0.wrap} !== 17'd0) begin
            failures++; $display("FAIL async_rst got=%h/%h/%b exp=00/00/0", b0.O1, b0.O2, b0.wrap);
        end
        tick();
        tick();
        rst = 1'b0;
        b0.FunSel = FS_HOLD; b0.RSel = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            b0.O1Sel = 3'(k);
            b0.O2Sel = 3'(k + 4);
            tick();
            checks++;
            if (b0.O1 !== 8'h00 || b0.O2 !== 8'h00) begin
                failures++; $display("FAIL post_rst_%0d got=%h/%h exp=00/00", k, b0.O1, b0.O2);
            end
        end
        checks++;
        if (b0.wrap !== 1'b0) begin failures++; $display("FAIL post_rst_wrap got=%b exp=0", b0.wrap); end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_wrap_modular();
        test_saturate();
        test_bypass();
        test_multi_shift();
        test_out_of_range();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
